// File: rtl/fas_spectrum_analysis_if.sv
// Frame and result bus between the 16-point FFT and the FAS spectrum analysis stage.
// Carries the optional max_mag result when FAS_ANALYSIS_MAG_OUT_EN is defined.
interface fas_spectrum_analysis_if #(
    parameter int DW  = 16,
    parameter int NPT = 16
);
    logic                fft_valid;
    logic [2*DW-1:0]     fft_d [NPT];
    logic                done;
    logic [3:0]          freq;
    logic                busy;
    logic                overflow;
`ifdef FAS_ANALYSIS_MAG_OUT_EN
    logic [2*DW:0]       max_mag;

    modport master (output fft_valid, fft_d, input done, freq, busy, overflow, max_mag);
    modport slave  (input fft_valid, fft_d, output done, freq, busy, overflow, max_mag);
`else
    modport master (output fft_valid, fft_d, input done, freq, busy, overflow);
    modport slave  (input fft_valid, fft_d, output done, freq, busy, overflow);
`endif
endinterface

// File: rtl/fas_spectrum_analysis.sv
// FAS analysis stage: scans each FFT frame one bin per cycle for the peak |X[k]|^2.
// Optional max_mag output is enabled by defining FAS_ANALYSIS_MAG_OUT_EN.
module fas_spectrum_analysis #(
    parameter int DW  = 16,
    parameter int NPT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    fas_spectrum_analysis_if.slave  bus
);
    localparam int            MW     = 2 * DW + 1;
    localparam logic [3:0]    LAST   = 4'(NPT - 1);
    localparam logic [0:0]    S_IDLE = 1'b0;
    localparam logic [0:0]    S_SCAN = 1'b1;

    logic [2*DW-1:0]  work_q [NPT];
    logic [2*DW-1:0]  pend_q [NPT];
    logic             pvld_q, pvld_d;
    logic [0:0]       state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [MW-1:0]    max_q, max_d;
    logic [3:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic [3:0]       freq_q, freq_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             work_from_in, work_from_pend, pend_from_in;

    logic signed [DW-1:0]   re, im;
    logic signed [2*DW-1:0] re_sq, im_sq;
    logic [MW-1:0]          mag, cand_max;
    logic [3:0]             cand_idx;
    logic                   is_new;

    // Squares are non-negative and fit 2*DW bits even for the most negative input.
    always_comb begin
        re       = work_q[count_q][2*DW-1:DW];
        im       = work_q[count_q][DW-1:0];
        re_sq    = re * re;
        im_sq    = im * im;
        mag      = {1'b0, re_sq} + {1'b0, im_sq};
        is_new   = (count_q == 4'd0) || (mag > max_q);
        cand_max = is_new ? mag : max_q;
        cand_idx = is_new ? count_q : idx_q;
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        max_d          = max_q;
        idx_d          = idx_q;
        done_d         = 1'b0;
        freq_d         = freq_q;
        pvld_d         = pvld_q;
        ovf_d          = ovf_q;
        work_from_in   = 1'b0;
        work_from_pend = 1'b0;
        pend_from_in   = 1'b0;
        busy_d         = (state_q == S_SCAN) | pvld_q;
        case (state_q)
            S_IDLE: begin
                if (bus.fft_valid) begin
                    work_from_in = 1'b1;
                    count_d      = 4'd0;
                    state_d      = S_SCAN;
                end
            end
            default: begin
                max_d   = cand_max;
                idx_d   = cand_idx;
                count_d = count_q + 4'd1;
                if (count_q == LAST) begin
                    done_d = 1'b1;
                    freq_d = cand_idx;
                    // A held frame goes first; a frame arriving now takes its place.
                    if (pvld_q) begin
                        work_from_pend = 1'b1;
                        pend_from_in   = bus.fft_valid;
                        pvld_d         = bus.fft_valid;
                    end else if (bus.fft_valid) begin
                        work_from_in = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.fft_valid) begin
                    if (!pvld_q) begin
                        pend_from_in = 1'b1;
                        pvld_d       = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            max_q   <= '0;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
            freq_q  <= 4'd0;
            pvld_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            freq_q  <= freq_d;
            pvld_q  <= pvld_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: frame buffers carry no reset; their contents are only read under a valid state/flag.
    always_ff @(posedge clk) begin
        if (work_from_pend) begin
            work_q <= pend_q;
        end else if (work_from_in) begin
            work_q <= bus.fft_d;
        end
        if (pend_from_in) begin
            pend_q <= bus.fft_d;
        end
    end

`ifdef FAS_ANALYSIS_MAG_OUT_EN
    logic [MW-1:0] mag_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_out_q <= '0;
        end else if (state_q == S_SCAN && count_q == LAST) begin
            mag_out_q <= cand_max;
        end
    end

    assign bus.max_mag = mag_out_q;
`endif

    assign bus.done     = done_q;
    assign bus.freq     = freq_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
endmodule
